// File: rtl/stopwatch_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl_fsm_pkg : state encodings and constants shared by the
//                          stopwatch controller, counter and tick generator
// Revision: 1.0
// ============================================================================
package stopwatch_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int CNT_MAX  = 9999;
  localparam int TICK_DIV = 10_000_000;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_fsm_lap_capture.sv
`default_nettype none
// ============================================================================
// lap_capture : lap hold register and its active flag
// Revision: 1.0
// ============================================================================
module lap_capture #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             lap_release,
  input  logic             flush,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_lap_active,
  output logic [CNT_W-1:0] o_lap_value
);

  // flush outranks capture so a clear always leaves a zeroed register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_lap_active <= 1'b0;
      o_lap_value  <= '0;
    end else if (flush) begin
      o_lap_active <= 1'b0;
      o_lap_value  <= '0;
    end else if (capture) begin
      o_lap_active <= 1'b1;
      o_lap_value  <= i_count;
    end else if (lap_release) begin
      o_lap_active <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl_fsm : run/stop/clear sequencing with lap-hold display path
// Revision: 1.0
// ============================================================================
module stopwatch_ctrl_fsm
  import stopwatch_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_mode,
  input  logic             i_run_stop,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_mode,
  output logic             o_run_stop,
  output logic             o_clear,
  output logic [CNT_W-1:0] o_disp_data,
  output logic             o_lap_active,
  output logic [1:0]       o_state
);

  state_t             r_state;
  state_t             w_next;
  logic               w_capture;
  logic               w_release;
  logic               w_flush;
  logic [CNT_W-1:0]   w_lap_value;

  // run/stop always wins over a coincident clear pulse
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_release = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run_stop) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_run_stop) begin
          w_next = ST_STOP;
        end else if (i_clear) begin
          w_capture = ~o_lap_active;
          w_release = o_lap_active;
        end
      end
      ST_STOP: begin
        if (i_run_stop) begin
          w_next = ST_RUN;
        end else if (i_clear) begin
          if (o_lap_active) begin
            w_release = 1'b1;
          end else begin
            w_next  = ST_CLEAR;
            w_flush = 1'b1;
          end
        end
      end
      ST_CLEAR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // direction is frozen for the whole run; sampled freely otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      o_run_stop <= 1'b0;
      o_clear    <= 1'b0;
      o_mode     <= 1'b0;
    end else begin
      r_state    <= w_next;
      o_run_stop <= (w_next == ST_RUN);
      o_clear    <= (w_next == ST_CLEAR);
      if (r_state != ST_RUN) o_mode <= i_mode;
    end
  end

  lap_capture #(
    .CNT_W (CNT_W)
  ) u_lap_capture (
    .clk          (clk),
    .reset        (reset),
    .capture      (w_capture),
    .lap_release  (w_release),
    .flush        (w_flush),
    .i_count      (i_count),
    .o_lap_active (o_lap_active),
    .o_lap_value  (w_lap_value)
  );

  assign o_state     = r_state;
  assign o_disp_data = o_lap_active ? w_lap_value : i_count;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_ctrl_fsm : directed and randomized checks of the stopwatch
//                         controller against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_stopwatch_ctrl_fsm;

  localparam int CNT_W = 14;
  localparam int C_MAX = 9999;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_mode = 1'b0;
  logic             i_run_stop = 1'b0;
  logic             i_clear = 1'b0;
  logic [CNT_W-1:0] i_count = '0;
  logic             o_mode;
  logic             o_run_stop;
  logic             o_clear;
  logic [CNT_W-1:0] o_disp_data;
  logic             o_lap_active;
  logic [1:0]       o_state;

  int n_pass  = 0;
  int n_total = 0;

  // behavioural model: phase numbers are the debug codes on o_state
  int               m_phase;
  logic             m_dir;
  logic             m_lap_on;
  logic [CNT_W-1:0] m_lap_val;

  stopwatch_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mode       (i_mode),
    .i_run_stop   (i_run_stop),
    .i_clear      (i_clear),
    .i_count      (i_count),
    .o_mode       (o_mode),
    .o_run_stop   (o_run_stop),
    .o_clear      (o_clear),
    .o_disp_data  (o_disp_data),
    .o_lap_active (o_lap_active),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_dir = 1'b0; m_lap_on = 1'b0; m_lap_val = '0;
  endtask

  task automatic model_edge(input logic rs, input logic clr, input logic md, input logic [CNT_W-1:0] cnt);
    if (m_phase != 1) m_dir = md;
    if (m_phase == 0) begin
      if (rs) m_phase = 1;
    end else if (m_phase == 1) begin
      if (rs) m_phase = 2;
      else if (clr && m_lap_on) m_lap_on = 1'b0;
      else if (clr) begin m_lap_on = 1'b1; m_lap_val = cnt; end
    end else if (m_phase == 2) begin
      if (rs) m_phase = 1;
      else if (clr && m_lap_on) m_lap_on = 1'b0;
      else if (clr) begin m_phase = 3; m_lap_val = '0; end
    end else begin
      m_phase = 0;
    end
  endtask

  // one clock of stimulus; the counter reacts to the controller's outputs
  task automatic cycle(input logic rs, input logic clr, input logic md);
    logic [CNT_W-1:0] nxt;
    i_run_stop = rs; i_clear = clr; i_mode = md;
    if (o_clear) nxt = '0;
    else if (!o_run_stop) nxt = i_count;
    else if (o_mode) nxt = (i_count == 0) ? CNT_W'(C_MAX) : i_count - 1'b1;
    else nxt = (i_count == CNT_W'(C_MAX)) ? '0 : i_count + 1'b1;
    @(posedge clk);
    model_edge(rs, clr, md, i_count);
    #1;
    i_count = nxt; i_run_stop = 1'b0; i_clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 i_count = 14'd77;
    #1;
    n_total++; if (o_state !== 2'd0) $display("FAIL reset_state got %0d want 0", o_state); else n_pass++;
    n_total++; if ({o_run_stop, o_clear, o_mode, o_lap_active} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {o_run_stop, o_clear, o_mode, o_lap_active}); else n_pass++;
    n_total++; if (o_disp_data !== 14'd77) $display("FAIL reset_disp got %0d want 77", o_disp_data); else n_pass++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_run_stop();
    cycle(1'b1, 1'b0, 1'b0);
    n_total++; if (o_state !== 2'd1 || o_run_stop !== 1'b1) $display("FAIL start got state %0d run %b want 1 1", o_state, o_run_stop); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    n_total++; if (o_state !== 2'd2 || o_run_stop !== 1'b0) $display("FAIL stop got state %0d run %b want 2 0", o_state, o_run_stop); else n_pass++;
  endtask

  task automatic test_clear();
    cycle(1'b0, 1'b1, 1'b0);
    n_total++; if (o_state !== 2'd3 || o_clear !== 1'b1) $display("FAIL clear_enter got state %0d clr %b want 3 1", o_state, o_clear); else n_pass++;
    cycle(1'b1, 1'b1, 1'b0);
    n_total++; if (o_state !== 2'd0 || o_clear !== 1'b0) $display("FAIL clear_exit got state %0d clr %b want 0 0", o_state, o_clear); else n_pass++;
    n_total++; if (i_count !== 14'd0) $display("FAIL clear_count got %0d want 0", i_count); else n_pass++;
  endtask

  task automatic test_lap();
    cycle(1'b1, 1'b0, 1'b0);
    i_count = 14'd1234;
    #1;
    cycle(1'b0, 1'b1, 1'b0);
    n_total++; if (o_lap_active !== 1'b1 || o_disp_data !== 14'd1234) $display("FAIL lap_capture got act %b disp %0d want 1 1234", o_lap_active, o_disp_data); else n_pass++;
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    n_total++; if (i_count !== 14'd1240 || o_disp_data !== 14'd1234) $display("FAIL lap_hold got cnt %0d disp %0d want 1240 1234", i_count, o_disp_data); else n_pass++;
    cycle(1'b0, 1'b1, 1'b0);
    n_total++; if (o_lap_active !== 1'b0 || o_disp_data !== i_count) $display("FAIL lap_release got act %b disp %0d want 0 %0d", o_lap_active, o_disp_data, i_count); else n_pass++;
    // lap held across stop: first clear releases, second clears
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    n_total++; if (o_state !== 2'd2 || o_lap_active !== 1'b0) $display("FAIL stop_release got state %0d act %b want 2 0", o_state, o_lap_active); else n_pass++;
    cycle(1'b0, 1'b1, 1'b0);
    n_total++; if (o_state !== 2'd3 || o_clear !== 1'b1) $display("FAIL stop_second_clear got state %0d clr %b want 3 1", o_state, o_clear); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mode_lock();
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    n_total++; if (o_mode !== 1'b0) $display("FAIL mode_locked got %b want 0", o_mode); else n_pass++;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    n_total++; if (o_state !== 2'd2 || o_mode !== 1'b1) $display("FAIL mode_after_stop got state %0d mode %b want 2 1", o_state, o_mode); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic seen_clear;
    cycle(1'b1, 1'b1, 1'b1);
    seen_clear = o_clear;
    repeat (3) begin
      cycle(1'b0, 1'b0, 1'b1);
      seen_clear |= o_clear;
    end
    n_total++; if (o_state !== 2'd1 || seen_clear !== 1'b0) $display("FAIL simultaneous got state %0d clr_seen %b want 1 0", o_state, seen_clear); else n_pass++;
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic rs, clr, md;
    md = i_mode;
    for (int k = 0; k < 400; k++) begin
      rs  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) md = ~md;
      if ($urandom_range(0, 15) == 0) begin i_count = CNT_W'($urandom_range(0, C_MAX)); #1; end
      cycle(rs, clr, md);
      n_total++; if (o_state !== 2'(m_phase)) $display("FAIL rnd_state k=%0d got %0d want %0d", k, o_state, m_phase); else n_pass++;
      n_total++; if (o_run_stop !== (m_phase == 1)) $display("FAIL rnd_run k=%0d got %b want %b", k, o_run_stop, m_phase == 1); else n_pass++;
      n_total++; if (o_clear !== (m_phase == 3)) $display("FAIL rnd_clear k=%0d got %b want %b", k, o_clear, m_phase == 3); else n_pass++;
      n_total++; if (o_mode !== m_dir) $display("FAIL rnd_mode k=%0d got %b want %b", k, o_mode, m_dir); else n_pass++;
      n_total++; if (o_lap_active !== m_lap_on) $display("FAIL rnd_lap k=%0d got %b want %b", k, o_lap_active, m_lap_on); else n_pass++;
      n_total++; if (o_disp_data !== (m_lap_on ? m_lap_val : i_count)) $display("FAIL rnd_disp k=%0d got %0d want %0d", k, o_disp_data, m_lap_on ? m_lap_val : i_count); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    while (m_phase != 1) cycle(1'b1, 1'b0, 1'b1);
    if (!m_lap_on) cycle(1'b0, 1'b1, 1'b1);
    #1 reset = 1'b1;
    #1;
    n_total++; if (o_state !== 2'd0 || o_run_stop !== 1'b0) $display("FAIL async_state got state %0d run %b want 0 0", o_state, o_run_stop); else n_pass++;
    n_total++; if ({o_clear, o_mode, o_lap_active} !== 3'b0) $display("FAIL async_flags got %b want 000", {o_clear, o_mode, o_lap_active}); else n_pass++;
    n_total++; if (o_disp_data !== i_count) $display("FAIL async_disp got %0d want %0d", o_disp_data, i_count); else n_pass++;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    cycle(1'b1, 1'b0, 1'b0);
    n_total++; if (o_state !== 2'd1 || o_lap_active !== 1'b0) $display("FAIL post_reset_run got state %0d act %b want 1 0", o_state, o_lap_active); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_stop();
    test_clear();
    test_lap();
    test_mode_lock();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
